// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types and defaults for the SRAM-backed data-bus responder.
package dbus_sram_responder_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        strobe_t     strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    localparam logic [63:0] DBUS_SRAM_BASE     = 64'h8000_0000;
    localparam int          DBUS_SRAM_DEPTH    = 4096;
    localparam int          DBUS_SRAM_LATENCY  = 2;
    localparam logic [15:0] DBUS_SRAM_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/dbus_sram_responder_sram_1rw_bytewe.sv
// Single-port 64-bit-wide SRAM: synchronous read, byte-enabled synchronous write.
module sram_1rw_bytewe #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_re,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_be,
    input  logic [63:0]   i_wdata,
    output logic [63:0]   o_rdata
);

    logic [63:0] r_mem [DEPTH];
    logic [63:0] r_rdata;

    // NOTE: the array and read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
        if (i_we) begin
            for (int b = 0; b < 8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus slave backed by a 64-bit SRAM with fixed access latency, one request in flight.
// Define DBUS_SRAM_RANDOM_STALL_EN to add 0..3 LFSR-chosen wait cycles per transaction.
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int          DEPTH     = DBUS_SRAM_DEPTH,
    parameter logic [63:0] BASE_ADDR = DBUS_SRAM_BASE,
    parameter int          LATENCY   = DBUS_SRAM_LATENCY
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int AW = $clog2(DEPTH);

    resp_state_t   r_state;
    logic [4:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic          r_in_range;
    strobe_t       r_strobe;
    logic [63:0]   r_wdata;
    logic          r_data_ok;

    logic [63:0]   w_off;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_extra;
    logic [4:0]    w_cnt_init;
    logic          w_accept;
    logic          w_to_resp;
    logic          w_we;
    logic [AW-1:0] w_mem_addr;
    logic [63:0]   w_rdata;
    logic          w_unused;

    // Out-of-range covers both addr below BASE_ADDR and offsets past the array.
    assign w_off      = dreq.addr - BASE_ADDR;
    assign w_in_range = (dreq.addr >= BASE_ADDR) && (w_off[63:AW+3] == '0);
    assign w_idx      = w_off[AW+2:3];
    assign w_unused   = ^{dreq.size, w_off[2:0]};

`ifdef DBUS_SRAM_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= DBUS_SRAM_LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_extra = r_lfsr[1:0];
`else
    assign w_extra = 2'b00;
`endif

    assign w_accept   = (r_state == IDLE) && dreq.valid;
    assign w_cnt_init = 5'(LATENCY - 1) + {3'b000, w_extra};
    // The read is launched one cycle ahead so the registered word lands in RESP.
    assign w_to_resp  = (w_accept && (w_cnt_init == '0)) ||
                        ((r_state == WAIT) && (r_cnt == 5'd1));
    assign w_we       = (r_state == RESP) && r_in_range && (r_strobe != '0);
    assign w_mem_addr = (r_state == IDLE) ? w_idx : r_idx;

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_in_range <= 1'b0;
            r_strobe   <= '0;
            r_wdata    <= '0;
            r_data_ok  <= 1'b0;
        end else begin
            r_data_ok <= w_to_resp;
            case (r_state)
                IDLE: begin
                    if (dreq.valid) begin
                        r_idx      <= w_idx;
                        r_in_range <= w_in_range;
                        r_strobe   <= dreq.strobe;
                        r_wdata    <= dreq.data;
                        r_cnt      <= w_cnt_init;
                        r_state    <= (w_cnt_init == '0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    sram_1rw_bytewe #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk     (clk),
        .i_re    (w_to_resp),
        .i_we    (w_we),
        .i_addr  (w_mem_addr),
        .i_be    (r_strobe),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    // NOTE: defaulting the whole struct first keeps this block free of latches.
    always_comb begin
        dresp         = '0;
        dresp.addr_ok = reset && w_accept;
        dresp.data_ok = r_data_ok;
        dresp.data    = (r_data_ok && r_in_range && !w_unused) ? w_rdata :
                        (r_data_ok && r_in_range) ? w_rdata : 64'h0;
    end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Randomised scoreboard bench for dbus_sram_responder against a word-level memory model.
module tb_dbus_sram_responder;
    import dbus_sram_responder_pkg::*;

    localparam logic [63:0] TB_BASE  = 64'h8000_0000;
    localparam int          TB_DEPTH = 4096;
    localparam int          LAT      = 2;
`ifdef DBUS_SRAM_RANDOM_STALL_EN
    localparam int          LAT_HI   = LAT + 3;
`else
    localparam int          LAT_HI   = LAT;
`endif

    typedef struct {
        logic [63:0] data;
        bit          chk;
    } exp_t;

    logic       clk;
    logic       reset;
    dbus_req_t  dreq;
    dbus_resp_t dresp;

    exp_t        sb_q[$];
    logic [63:0] mem_model [longint unsigned];
    logic [63:0] pool [16];
    logic [63:0] oor  [4];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int acc_cyc   = 0;
    int acc_count = 0;
    int dok_count = 0;
    int aborted   = 0;
    bit in_flight = 0;

    dbus_sram_responder #(
        .DEPTH     (TB_DEPTH),
        .BASE_ADDR (TB_BASE),
        .LATENCY   (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dreq  (dreq),
        .dresp (dresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, val, lo, hi, $time);
        end
    endtask

    // Reference memory: whole 64-bit words keyed by word index; returns the pre-write word.
    function automatic void model(input logic [63:0] addr, input logic [7:0] strobe,
                                  input logic [63:0] data, output exp_t e);
        longint unsigned idx;
        logic [63:0]     w;
        if (addr < TB_BASE || ((addr - TB_BASE) >> 3) >= 64'(TB_DEPTH)) begin
            e.data = 64'h0;
            e.chk  = 1'b1;
            return;
        end
        idx    = (addr - TB_BASE) >> 3;
        e.chk  = mem_model.exists(idx);
        e.data = e.chk ? mem_model[idx] : 64'h0;
        if (strobe != 8'h00 && (e.chk || strobe == 8'hFF)) begin
            w = e.data;
            for (int b = 0; b < 8; b++) begin
                if (strobe[b]) w[b*8 +: 8] = data[b*8 +: 8];
            end
            mem_model[idx] = w;
        end
    endfunction

    // Called just after a rising edge; returns just after the edge that ends RESP.
    task automatic issue(input logic [63:0] addr, input logic [7:0] strobe, input logic [63:0] data);
        exp_t e;
        bit   seen;
        model(addr, strobe, data, e);
        sb_q.push_back(e);
        dreq.valid  = 1'b1;
        dreq.addr   = addr;
        dreq.size   = msize_t'($urandom_range(0, 3));
        dreq.strobe = strobe;
        dreq.data   = data;
        @(negedge clk);
        check("addr_ok_cycle0", dresp.addr_ok, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (dresp.data_ok) seen = 1'b1;
        end
        check("data_ok_timeout", seen, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dreq.valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pairs each data_ok with the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                sb_q.delete();
                in_flight = 1'b0;
            end else begin
                if (dresp.data_ok) begin
                    dok_count++;
                    check("data_ok_has_accept", in_flight, 1'b1);
                    check("sb_not_empty", sb_q.size() > 0, 1'b1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        if (e.chk) check("rdata", dresp.data, e.data);
                        check_range("latency", cyc - acc_cyc, LAT, LAT_HI);
                    end
                    in_flight = 1'b0;
                end else begin
                    check("data_zero_when_idle", dresp.data, 64'h0);
                end
                if (dreq.valid && dresp.addr_ok) begin
                    check("accept_while_busy", in_flight, 1'b0);
                    in_flight = 1'b1;
                    acc_cyc   = cyc;
                    acc_count++;
                end
            end
        end
    end

    initial begin
        int dok;
        reset = 1'b0;
        dreq  = '0;

        repeat (3) begin
            @(negedge clk);
            check("reset_dresp_zero", dresp, '0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle_dresp_zero", dresp, '0);
        end
        @(posedge clk);
        #1;

        // Full write, read-back, partial strobe.
        issue(64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788);
        issue(64'h8000_0010, 8'h00, 64'h0);
        issue(64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA);
        issue(64'h8000_0010, 8'h00, 64'h0);

        // Out-of-range: below base reads zero; write past end must not alias word 0.
        issue(TB_BASE, 8'hFF, 64'h0123_4567_89AB_CDEF);
        issue(64'h7FFF_FFF8, 8'h00, 64'h0);
        issue(TB_BASE + 64'(TB_DEPTH) * 8, 8'hFF, 64'hFFFF_0000_FFFF_0000);
        issue(TB_BASE, 8'h00, 64'h0);
        issue(64'h8000_0010, 8'h00, 64'h0);
        idle(2);

        // Reset during WAIT: write is abandoned, no data_ok, old data survives.
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_0010;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'hDEAD_BEEF_0BAD_F00D;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        dreq.valid = 1'b0;
        aborted++;
        dok = 0;
        repeat (3) begin
            @(negedge clk);
            if (dresp.data_ok) dok++;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("no_data_ok_across_reset", dok, 0);
        issue(64'h8000_0010, 8'h00, 64'h0);

        // Randomised traffic over a small address pool.
        pool[0] = TB_BASE;
        pool[1] = TB_BASE + 64'(TB_DEPTH - 1) * 8;
        for (int i = 2; i < 16; i++) pool[i] = TB_BASE + 64'($urandom_range(0, TB_DEPTH - 1)) * 8;
        oor[0] = TB_BASE - 8;
        oor[1] = TB_BASE + 64'(TB_DEPTH) * 8;
        oor[2] = 64'h0;
        oor[3] = 64'hFFFF_FFFF_FFFF_FFF8;
        for (int i = 0; i < 16; i++) issue(pool[i], 8'hFF, {$urandom, $urandom});
        for (int i = 0; i < 1000; i++) begin
            logic [63:0] a;
            logic [7:0]  s;
            a = ($urandom_range(0, 9) == 0) ? oor[$urandom_range(0, 3)] : pool[$urandom_range(0, 15)];
            a = a | 64'($urandom_range(0, 7));
            s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            issue(a, s, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(5);

        check("sb_drained", sb_q.size(), 0);
        check("one_data_ok_per_accept", acc_count - aborted, dok_count);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
